// File: rtl/rv32_pkg.sv
// Shared RV32I MEM-stage definitions: writeback select codes, funct3 sizes, LSU states.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package rv32_pkg;

  // Writeback select codes
  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // funct3 load/store size and sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;

  // Access size; any funct3 outside the RV32I load/store set behaves as a word.
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    mem_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  // Byte offset actually used on the bus: bits that would make the access
  // misaligned are cleared so the access stays inside one word.
  function automatic logic [1:0] aligned_off(input mem_size_e sz, input logic [1:0] a);
    logic [1:0] o;
    case (sz)
      SZ_B:    o = a;
      SZ_H:    o = {a[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

  function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] a);
    logic m;
    case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatting: picks the addressed byte/half lane and sign/zero extends.
// Latency: combinational.
// Backpressure: none.
module lsu_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  import rv32_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension chosen by funct3
  always_comb begin
    byte_sel = rdata[7:0];
    case (a)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one valid/ready bus access per memory op and writes MEM/WB regs.
// Latency: non-memory ops 1 cycle; memory ops >= 3 cycles (IDLE->REQ, accept, response).
// Backpressure: stall_MEM holds the pipeline until the bus response arrives. Optional MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_MEM,
  input  logic [XLEN-1:0] alu_MEM,
  input  logic [XLEN-1:0] rs2_MEM,
  input  logic            regwen_MEM,
  input  logic            MemRW_MEM,
  input  logic            mem_en_MEM,
  input  logic [2:0]      funct3_MEM,
  input  logic [1:0]      WBsel_MEM,
  input  logic [4:0]      dest_MEM,
  output logic            dbus_req_valid,
  input  logic            dbus_req_ready,
  output logic [XLEN-1:0] dbus_addr,
  output logic            dbus_we,
  output logic [3:0]      dbus_wstrb,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_rsp_valid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            stall_MEM,
`ifdef MISALIGN_TRAP_EN
  output logic            misalign_MEM,
`endif
  output logic [XLEN-1:0] wb_data_WB,
  output logic            regwen_WB,
  output logic [4:0]      dest_WB
);
  import rv32_pkg::*;

  lsu_state_e state_q, state_d;

  // Access fields captured when a memory op starts; the bus sees only these.
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            we_q;
  logic [3:0]      wstrb_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [4:0]      dest_q;
  logic            regwen_q;

  mem_size_e       sz;
  logic [1:0]      off;
  logic [3:0]      wstrb_c;
  logic [XLEN-1:0] wdata_c;
  logic            trap;
  logic            start;
  logic            done;
  logic [XLEN-1:0] load_data;

  // Store lane formatting from the live EX/MEM fields
  always_comb begin
    sz      = f3_size(funct3_MEM);
    off     = aligned_off(sz, alu_MEM[1:0]);
    wstrb_c = 4'b0000;
    wdata_c = rs2_MEM;
    case (sz)
      SZ_B: begin
        wstrb_c = 4'b0001 << off;
        wdata_c = {4{rs2_MEM[7:0]}};
      end
      SZ_H: begin
        wstrb_c = 4'b0011 << {off[1], 1'b0};
        wdata_c = {2{rs2_MEM[15:0]}};
      end
      default: begin
        wstrb_c = 4'hF;
        wdata_c = rs2_MEM;
      end
    endcase
    if (!MemRW_MEM) wstrb_c = 4'b0000;
  end

`ifdef MISALIGN_TRAP_EN
  // A misaligned access never reaches the bus; it retires as a one-cycle bubble.
  assign trap         = mem_en_MEM && is_misaligned(sz, alu_MEM[1:0]);
  assign misalign_MEM = (state_q == IDLE) && trap;
`else
  assign trap = 1'b0;
`endif

  // Next-state, stall and request-valid decode
  always_comb begin
    state_d        = state_q;
    stall_MEM      = 1'b0;
    dbus_req_valid = 1'b0;
    start          = 1'b0;
    done           = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_en_MEM && !trap) begin
          stall_MEM = 1'b1;
          start     = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        stall_MEM      = 1'b1;
        dbus_req_valid = 1'b1;
        if (dbus_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (dbus_rsp_valid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          stall_MEM = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the access when it starts so the request stays stable until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= 4'b0000;
      f3_q     <= 3'b000;
      off_q    <= 2'b00;
      dest_q   <= 5'd0;
      regwen_q <= 1'b0;
    end else if (start) begin
      addr_q   <= {alu_MEM[XLEN-1:2], 2'b00};
      wdata_q  <= wdata_c;
      we_q     <= MemRW_MEM;
      wstrb_q  <= wstrb_c;
      f3_q     <= funct3_MEM;
      off_q    <= off;
      dest_q   <= dest_MEM;
      regwen_q <= regwen_MEM;
    end
  end

  assign dbus_addr  = addr_q;
  assign dbus_we    = we_q;
  assign dbus_wstrb = wstrb_q;
  assign dbus_wdata = wdata_q;

  lsu_load_align u_load_align (
    .rdata  (dbus_rdata),
    .a      (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  // MEM/WB registers: ALU/PC+4 ops pass through, completions write load data, everything else is a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_WB <= '0;
      regwen_WB  <= 1'b0;
      dest_WB    <= 5'd0;
    end else if (state_q == IDLE && !mem_en_MEM) begin
      case (WBsel_MEM)
        WB_ALU:  wb_data_WB <= alu_MEM;
        WB_PC4:  wb_data_WB <= pc_MEM + XLEN'(4);
        default: wb_data_WB <= alu_MEM;
      endcase
      regwen_WB <= regwen_MEM;
      dest_WB   <= dest_MEM;
    end else if (done) begin
      dest_WB <= dest_q;
      if (we_q) begin
        regwen_WB <= 1'b0;
      end else begin
        wb_data_WB <= load_data;
        regwen_WB  <= regwen_q;
      end
    end else begin
      regwen_WB <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector tables for ALU/PC+4 ops, loads and stores,
// plus hand sequences for delayed handshakes, reset during WAIT and misaligned accesses.
module tb_mem_stage_lsu;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_MEM, alu_MEM, rs2_MEM;
  logic        regwen_MEM, MemRW_MEM, mem_en_MEM;
  logic [2:0]  funct3_MEM;
  logic [1:0]  WBsel_MEM;
  logic [4:0]  dest_MEM;
  logic        dbus_req_valid, dbus_req_ready;
  logic [31:0] dbus_addr;
  logic        dbus_we;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_wdata;
  logic        dbus_rsp_valid;
  logic [31:0] dbus_rdata;
  logic        stall_MEM;
  logic [31:0] wb_data_WB;
  logic        regwen_WB;
  logic [4:0]  dest_WB;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_MEM;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .pc_MEM(pc_MEM), .alu_MEM(alu_MEM), .rs2_MEM(rs2_MEM),
    .regwen_MEM(regwen_MEM), .MemRW_MEM(MemRW_MEM), .mem_en_MEM(mem_en_MEM),
    .funct3_MEM(funct3_MEM), .WBsel_MEM(WBsel_MEM), .dest_MEM(dest_MEM),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_addr(dbus_addr), .dbus_we(dbus_we), .dbus_wstrb(dbus_wstrb),
    .dbus_wdata(dbus_wdata), .dbus_rsp_valid(dbus_rsp_valid), .dbus_rdata(dbus_rdata),
    .stall_MEM(stall_MEM),
`ifdef MISALIGN_TRAP_EN
    .misalign_MEM(misalign_MEM),
`endif
    .wb_data_WB(wb_data_WB), .regwen_WB(regwen_WB), .dest_WB(dest_WB)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [1:0]  wbsel;
    logic        regwen;
    logic [4:0]  dest;
    logic [31:0] exp_data;
  } alu_vec_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] exp_wb;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    int          exp_stall;
  } mem_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_en_MEM = 1'b0; MemRW_MEM = 1'b0; dbus_req_ready = 1'b0;
    dbus_rsp_valid = 1'b0; dbus_rdata = 32'h0;
  endtask

  // Runs one memory op through the handshake with the given ready/response delays.
  task automatic run_mem(input string nm, input mem_vec_t v);
    int req_cyc = 0, wait_cyc = 0, stall_cnt = 0;
    logic accepted = 1'b0, done = 1'b0, first = 1'b1, stable = 1'b1, bubble_ok = 1'b1;
    logic [31:0] a0 = 0, d0 = 0, wb_before;
    logic [3:0]  s0 = 0;
    logic        w0 = 0;
    wb_before  = wb_data_WB;
    mem_en_MEM = 1'b1; MemRW_MEM = v.we; funct3_MEM = v.f3; alu_MEM = v.addr;
    rs2_MEM = v.wd; regwen_MEM = 1'b1; dest_MEM = 5'd7; WBsel_MEM = WB_MEM;
    dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rdata = 32'h5A5A5A5A;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      dbus_req_ready = 1'b0;
      dbus_rsp_valid = 1'b0;
      if (dbus_req_valid) begin
        if (first) begin
          a0 = dbus_addr; s0 = dbus_wstrb; d0 = dbus_wdata; w0 = dbus_we; first = 1'b0;
        end else if (dbus_addr !== a0 || dbus_wstrb !== s0 || dbus_wdata !== d0 || dbus_we !== w0) begin
          stable = 1'b0;
        end
        if (req_cyc == v.rdy_dly) begin
          dbus_req_ready = 1'b1;
          accepted = 1'b1;
        end
        req_cyc++;
      end else if (accepted) begin
        if (wait_cyc == v.rsp_dly) begin
          dbus_rsp_valid = 1'b1;
          dbus_rdata = v.rdata;
          done = 1'b1;
        end
        wait_cyc++;
      end
      #1;
      if (stall_MEM) stall_cnt++;
      if (cyc > 0 && (regwen_WB !== 1'b0 || wb_data_WB !== wb_before)) bubble_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_addr"}, a0, {v.addr[31:2], 2'b00});
    chk({nm, "_we"}, {31'd0, w0}, {31'd0, v.we});
    chk({nm, "_wstrb"}, {28'd0, s0}, {28'd0, v.exp_wstrb});
    chk({nm, "_stall"}, stall_cnt, v.exp_stall);
    chk({nm, "_bubble"}, {31'd0, bubble_ok}, 32'd1);
    if (v.we) begin
      chk({nm, "_wdata"}, d0, v.exp_wdata);
      chk({nm, "_stable"}, {31'd0, stable}, 32'd1);
      chk({nm, "_regwen"}, {31'd0, regwen_WB}, 32'd0);
    end else begin
      chk({nm, "_wb"}, wb_data_WB, v.exp_wb);
      chk({nm, "_regwen"}, {31'd0, regwen_WB}, 32'd1);
      chk({nm, "_dest"}, {27'd0, dest_WB}, 32'd7);
    end
  endtask

  alu_vec_t alu_tab[4];
  mem_vec_t mem_tab[10];

  initial begin
    alu_tab[0] = '{32'h0000_0000, 32'h0000_1234, WB_ALU, 1'b1, 5'd5,  32'h0000_1234};
    alu_tab[1] = '{32'h0000_0100, 32'hDEAD_BEEF, WB_PC4, 1'b1, 5'd1,  32'h0000_0104};
    alu_tab[2] = '{32'hFFFF_FFFC, 32'h0000_0000, WB_PC4, 1'b1, 5'd31, 32'h0000_0000};
    alu_tab[3] = '{32'h0000_0040, 32'h8000_0001, WB_ALU, 1'b0, 5'd0,  32'h8000_0001};

    //             we    f3     addr          wd            rdata         rdy rsp exp_wb        wstrb    wdata         stall
    mem_tab[0] = '{1'b0, F3_B,  32'h0000_1003, 32'h0,        32'h80FF_FFFF, 0, 0, 32'hFFFF_FF80, 4'b0000, 32'h0,        2};
    mem_tab[1] = '{1'b0, F3_BU, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 0, 0, 32'h0000_0080, 4'b0000, 32'h0,        2};
    mem_tab[2] = '{1'b0, F3_B,  32'h0000_1001, 32'h0,        32'h1234_7F56, 0, 0, 32'h0000_007F, 4'b0000, 32'h0,        2};
    mem_tab[3] = '{1'b0, F3_H,  32'h0000_1002, 32'h0,        32'h8001_1234, 0, 0, 32'hFFFF_8001, 4'b0000, 32'h0,        2};
    mem_tab[4] = '{1'b0, F3_HU, 32'h0000_0000, 32'h0,        32'h0000_F00D, 0, 4, 32'h0000_F00D, 4'b0000, 32'h0,        6};
    mem_tab[5] = '{1'b0, F3_W,  32'h0000_1000, 32'h0,        32'hCAFE_F00D, 1, 1, 32'hCAFE_F00D, 4'b0000, 32'h0,        4};
    mem_tab[6] = '{1'b0, 3'b011, 32'h0000_1000, 32'h0,       32'h1357_9BDF, 0, 0, 32'h1357_9BDF, 4'b0000, 32'h0,        2};
    mem_tab[7] = '{1'b1, F3_H,  32'h0000_2002, 32'hABCD_1234, 32'h0,        3, 0, 32'h0,        4'b1100, 32'h1234_1234, 5};
    mem_tab[8] = '{1'b1, F3_B,  32'h0000_2001, 32'h0000_00A5, 32'h0,        0, 2, 32'h0,        4'b0010, 32'hA5A5_A5A5, 4};
    mem_tab[9] = '{1'b1, F3_W,  32'h0000_2000, 32'h1122_3344, 32'h0,        0, 0, 32'h0,        4'b1111, 32'h1122_3344, 2};

    // Reset state
    rst = 1'b1; pc_MEM = 0; alu_MEM = 0; rs2_MEM = 0; regwen_MEM = 0; funct3_MEM = 0;
    WBsel_MEM = WB_ALU; dest_MEM = 0; idle_inputs();
    tick(); tick();
    chk("rst_wb", wb_data_WB, 32'h0);
    chk("rst_regwen", {31'd0, regwen_WB}, 32'd0);
    chk("rst_dest", {27'd0, dest_WB}, 32'd0);
    chk("rst_req", {31'd0, dbus_req_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_MEM}, 32'd0);
    rst = 1'b0;

    // Single-cycle ALU / PC+4 ops
    for (int i = 0; i < 4; i++) begin
      pc_MEM = alu_tab[i].pc; alu_MEM = alu_tab[i].alu; WBsel_MEM = alu_tab[i].wbsel;
      regwen_MEM = alu_tab[i].regwen; dest_MEM = alu_tab[i].dest; mem_en_MEM = 1'b0;
      #1;
      chk($sformatf("alu%0d_stall", i), {31'd0, stall_MEM}, 32'd0);
      tick();
      chk($sformatf("alu%0d_wb", i), wb_data_WB, alu_tab[i].exp_data);
      chk($sformatf("alu%0d_regwen", i), {31'd0, regwen_WB}, {31'd0, alu_tab[i].regwen});
      chk($sformatf("alu%0d_dest", i), {27'd0, dest_WB}, {27'd0, alu_tab[i].dest});
    end

    // Loads and stores, including delayed ready/response handshakes
    for (int i = 0; i < 10; i++) run_mem($sformatf("mem%0d", i), mem_tab[i]);

    // Reset while waiting for a response; the late response must be ignored
    mem_en_MEM = 1'b1; MemRW_MEM = 1'b0; funct3_MEM = F3_W; alu_MEM = 32'h0000_4000;
    regwen_MEM = 1'b1; dest_MEM = 5'd9;
    tick();
    dbus_req_ready = 1'b1;
    #1;
    chk("rstw_req", {31'd0, dbus_req_valid}, 32'd1);
    tick();
    dbus_req_ready = 1'b0;
    #1;
    chk("rstw_wait_stall", {31'd0, stall_MEM}, 32'd1);
    rst = 1'b1; mem_en_MEM = 1'b0; alu_MEM = 32'h0; regwen_MEM = 1'b0; dest_MEM = 5'd0;
    WBsel_MEM = WB_ALU;
    tick();
    rst = 1'b0; dbus_rsp_valid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rstw_stall", {31'd0, stall_MEM}, 32'd0);
    tick();
    dbus_rsp_valid = 1'b0;
    chk("rstw_wb", wb_data_WB, 32'h0);
    chk("rstw_regwen", {31'd0, regwen_WB}, 32'd0);
    chk("rstw_dest", {27'd0, dest_WB}, 32'd0);
    chk("rstw_req", {31'd0, dbus_req_valid}, 32'd0);
    chk("rstw_addr", dbus_addr, 32'h0);
    chk("rstw_wstrb", {28'd0, dbus_wstrb}, 32'd0);
    chk("rstw_wdata", dbus_wdata, 32'h0);
    run_mem("after_rst", '{1'b0, F3_W, 32'h0000_4004, 32'h0, 32'h0BAD_CAFE, 0, 0,
                           32'h0BAD_CAFE, 4'b0000, 32'h0, 2});

`ifdef MISALIGN_TRAP_EN
    // Misaligned accesses trap in one cycle without touching the bus
    alu_MEM = 32'h0000_0055; WBsel_MEM = WB_ALU; regwen_MEM = 1'b1; dest_MEM = 5'd3;
    tick();
    chk("pre_trap_regwen", {31'd0, regwen_WB}, 32'd1);
    mem_en_MEM = 1'b1; MemRW_MEM = 1'b0; funct3_MEM = F3_W; alu_MEM = 32'h0000_3001;
    #1;
    chk("trap_req", {31'd0, dbus_req_valid}, 32'd0);
    chk("trap_stall", {31'd0, stall_MEM}, 32'd0);
    chk("trap_flag", {31'd0, misalign_MEM}, 32'd1);
    tick();
    mem_en_MEM = 1'b0; regwen_MEM = 1'b0;
    #1;
    chk("trap_regwen", {31'd0, regwen_WB}, 32'd0);
    chk("trap_flag_clr", {31'd0, misalign_MEM}, 32'd0);
    chk("trap_req_after", {31'd0, dbus_req_valid}, 32'd0);
    mem_en_MEM = 1'b1; MemRW_MEM = 1'b1; funct3_MEM = F3_H; alu_MEM = 32'h0000_3003;
    #1;
    chk("trap_sh_flag", {31'd0, misalign_MEM}, 32'd1);
    chk("trap_sh_stall", {31'd0, stall_MEM}, 32'd0);
    tick();
    idle_inputs();
`else
    // Misaligned accesses proceed with the offending low bits cleared
    run_mem("mis_lw", '{1'b0, F3_W, 32'h0000_3001, 32'h0, 32'h89AB_CDEF, 0, 0,
                        32'h89AB_CDEF, 4'b0000, 32'h0, 2});
    run_mem("mis_lh", '{1'b0, F3_H, 32'h0000_1003, 32'h0, 32'hBEEF_0000, 0, 0,
                        32'hFFFF_BEEF, 4'b0000, 32'h0, 2});
    run_mem("mis_sw", '{1'b1, F3_W, 32'h0000_3002, 32'h7654_3210, 32'h0, 0, 0,
                        32'h0, 4'b1111, 32'h7654_3210, 2});
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs in the RV32I 5-stage core.
- Turns load/store fields into a valid/ready data-bus transaction, waits for the response, and formats load data (lane select, sign/zero extend).
- Holds the pipeline with a stall while an access is outstanding.
- Drives the MEM/WB-side registered outputs: writeback data, regwen, dest.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- WB_MEM, 2'd0, WBsel code selecting load data.
- WB_ALU, 2'd1, WBsel code selecting alu_MEM.
- WB_PC4, 2'd2, WBsel code selecting pc_MEM+4.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous reset, active-high
- pc_MEM  in  32  instruction PC
- alu_MEM  in  32  ALU result / effective address
- rs2_MEM  in  32  store data
- regwen_MEM  in  1  register write enable
- MemRW_MEM  in  1  1=store, 0=load (valid only when mem_en_MEM=1)
- mem_en_MEM  in  1  instruction accesses memory
- funct3_MEM  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- WBsel_MEM  in  2  writeback select
- dest_MEM  in  5  destination register
- dbus_req_valid  out  1  request valid
- dbus_req_ready  in  1  request accepted
- dbus_addr  out  32  word-aligned address ({alu[31:2],2'b00})
- dbus_we  out  1  write request
- dbus_wstrb  out  4  byte strobes
- dbus_wdata  out  32  lane-replicated store data
- dbus_rsp_valid  in  1  response/ack valid (exactly one per accepted request)
- dbus_rdata  in  32  read word
- stall_MEM  out  1  hold IF..EX and the EX/MEM register
- wb_data_WB  out  32  registered writeback data
- regwen_WB  out  1  registered writeback enable
- dest_WB  out  5  registered destination

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; wb_data_WB=0; regwen_WB=0; dest_WB=0; dbus_req_valid=0.
- Reset mid-transaction abandons the access. A late dbus_rsp_valid arriving in IDLE is ignored.
- Non-memory op (mem_en=0): 1-cycle latency; WB registers load ALU or PC+4 data, regwen_MEM, dest_MEM; stall=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, mem_en=1: stall=1, latch addr/we/wstrb/wdata/funct3/addr[1:0]/dest/regwen; go REQ.
  - REQ: req_valid=1, request fields stable and held until dbus_req_ready=1; then go WAIT.
  - WAIT: on dbus_rsp_valid, return to IDLE and write the WB registers the same edge (load: formatted data, latched regwen/dest; store: regwen_WB=0).
- stall_MEM is combinational: (IDLE & mem_en) | REQ | (WAIT & ~dbus_rsp_valid). It deasserts in the completion cycle, so the pipeline advances on the same edge.
- Stall cycles write a bubble: regwen_WB=0, wb_data_WB held.
- Minimum memory-op latency is 3 cycles: IDLE→REQ, REQ accepted, response in the next cycle. Inputs are stable during a stall because the pipeline is held.
- Load formatting (a=addr[1:0]):
  - B/BU: byte rdata[8a+7:8a], sign- or zero-extended.
  - H/HU: half rdata[16a+15:16a] using a[1], extended.
  - W: full word.
- Store formatting:
  - SB: wstrb=4'b0001<<a, wdata={4{rs2[7:0]}}.
  - SH: wstrb=4'b0011<<(2*a[1]), wdata={2{rs2[15:0]}}.
  - SW: wstrb=4'hF, wdata=rs2.
- Loads drive wstrb=0.
- Misaligned access (H with a[0]=1, W with a≠0): without the optional feature, offending low address bits are treated as 0.
- Unsupported funct3 values are treated as W.
- dest=0 writes are not special-cased here; the register file ignores x0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Enabled: adds output misalign_MEM (1 bit).
  - A misaligned access issues no bus request and completes in 1 cycle.
  - regwen_WB=0; misalign_MEM=1 pulses for that cycle only; stall=0.
- Disabled: port absent; the misaligned access proceeds with the low bits forced to 0, as in Behaviour.

Decomposition:
- Shared package rv32_pkg holds:
  - WB_MEM/WB_ALU/WB_PC4 codes.
  - funct3 load/store size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - LSU state enum {IDLE, REQ, WAIT}.
- One natural sub-module: lsu_load_align, a combinational lane-select plus sign/zero extend taking rdata, a, funct3.

Test Plan:
- ALU op alu=0x1234, WBsel=ALU, regwen=1, dest=5 → next edge wb_data_WB=0x1234, regwen_WB=1, dest_WB=5, stall never asserted.
- LB addr=0x1003, ready tied 1, rdata=0x80FFFFFF one cycle after accept → stall high 2 cycles; wb_data_WB=0xFFFFFF80, dbus_addr=0x1000.
- SH addr=0x2002, rs2=0xABCD1234, ready delayed 3 cycles → req fields held stable; wstrb=4'b1100, wdata=0x12341234; completion gives regwen_WB=0.
- LHU addr=0x0, rdata=0x0000F00D, rsp delayed 4 cycles → stall held through WAIT, wb_data_WB=0x0000F00D, bubbles (regwen_WB=0) during stall.
- rst=1 asserted while in WAIT, then rsp_valid=1 → state IDLE, no WB write, req_valid=0, all outputs 0.
- MISALIGN_TRAP_EN: LW addr=0x3001 → no req_valid, misalign_MEM=1 one cycle, regwen_WB=0. Without the macro: dbus_addr=0x3000 and a normal load.
